// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
//   Instruction handshake bundle between the fetch/test front-end (master)
//   and alu_seq_ctrl (slave).
//
//   Handshake: a word transfers on a rising clock edge where inst_valid and
//   inst_ready are both 1. The master keeps inst stable while inst_valid is
//   high. inst_ready does not depend on inst_valid.
//
//   Signals:
//     inst_valid  master -> slave  instruction word valid
//     inst        master -> slave  32-bit instruction word
//     inst_ready  slave -> master  slave can accept a word this cycle
interface alu_seq_ctrl_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;

  modport master (
    output inst_valid,
    output inst,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst,
    output inst_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Instruction-side sequencer for the external combinational ALU. Takes one
//   instruction word at a time, decodes it, reads operands from a 16x32
//   register file, holds the ALU inputs for EXEC_CYCLES cycles, captures the
//   ALU result and writes it back to R[rd].
//
//   Instruction word: [31:28] opcode, [27:25] sr_cont, [24:20] sr_bit,
//   [19:16] rd, [15:12] rn, [11:8] rm, [7:0] ignored.
//   Legal only when opcode <= 5 and sr_cont <= 3.
//
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     inst_if (slave)       inst_valid / inst_ready / inst handshake
//     alu_in1, alu_in2      registered operands R[rn], R[rm]
//     alu_opcode, alu_sr_cont, alu_sr_bit   registered ALU controls
//     alu_out               combinational ALU result
//     done, err             retire pulse; err marks an illegal instruction
//     result                last captured ALU result, held
//     cfg_we/addr/wdata     external register write port, any state
//     cfg_drop              pulse: cfg write lost to a same-edge writeback
//     dbg_addr, dbg_data    combinational register read
//     dbg_state             current sequencer state
//
//   Optional build macro ALU_SEQ_PERF_EN adds perf_retired[31:0] and
//   perf_illegal[15:0] counters.
module alu_seq_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned NREGS       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_ctrl_if.slave inst_if,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  input  logic [31:0] alu_out,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_drop,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [1:0]  dbg_state
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [15:0] perf_illegal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] inst_q;               // instruction bits [31:8]
  logic        err_q;
  logic [31:0] result_q;
  logic [31:0] in1_q, in2_q;
  logic [3:0]  op_q;
  logic [2:0]  sc_q;
  logic [4:0]  sb_q;
  logic        drop_q;
  logic [31:0] regs_q [NREGS];

  logic [3:0]  f_op, f_rd, f_rn, f_rm;
  logic [2:0]  f_sc;
  logic [4:0]  f_sb;
  logic        legal;
  logic        wb_fire, wb_we, cfg_hit, cfg_lost, cfg_ok;
  logic        unused_inst_low;

  assign unused_inst_low = ^inst_if.inst[7:0];

  assign f_op = inst_q[23:20];
  assign f_sc = inst_q[19:17];
  assign f_sb = inst_q[16:12];
  assign f_rd = inst_q[11:8];
  assign f_rn = inst_q[7:4];
  assign f_rm = inst_q[3:0];

  assign legal = (f_op <= 4'd5) && (f_sc <= 3'd3);

  // Writeback happens on the edge that ends the last EXEC cycle.
  assign wb_fire  = (state_q == S_EXEC) && (cnt_q == 4'd0);
  assign wb_we    = wb_fire && (f_rd != 4'd0);
  // R0 is never written; a cfg write to the writeback target loses.
  assign cfg_hit  = cfg_we && (cfg_addr != 4'd0);
  assign cfg_lost = cfg_hit && wb_we && (cfg_addr == f_rd);
  assign cfg_ok   = cfg_hit && !cfg_lost;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inst_if.inst_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
          cnt_d   = EXEC_INIT;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) state_d = S_WB;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      inst_q   <= 24'd0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
      in1_q    <= 32'd0;
      in2_q    <= 32'd0;
      op_q     <= 4'd0;
      sc_q     <= 3'd0;
      sb_q     <= 5'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= cfg_lost;
      if (state_q == S_IDLE && inst_if.inst_valid) inst_q <= inst_if.inst[31:8];
      if (state_q == S_DECODE) begin
        err_q <= !legal;
        // Operands come from the registered file contents; a cfg write on
        // this same edge is not forwarded.
        if (legal) begin
          in1_q <= regs_q[f_rn];
          in2_q <= regs_q[f_rm];
          op_q  <= f_op;
          sc_q  <= f_sc;
          sb_q  <= f_sb;
        end
      end
      if (wb_fire) result_q <= alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
    end else begin
      if (cfg_ok) regs_q[cfg_addr] <= cfg_wdata;
      if (wb_we)  regs_q[f_rd]     <= alu_out;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_retired_q;
  logic [15:0] perf_illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= 32'd0;
      perf_illegal_q <= 16'd0;
    end else if (state_q == S_WB) begin
      perf_retired_q <= perf_retired_q + 32'd1;
      if (err_q) perf_illegal_q <= perf_illegal_q + 16'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_illegal = perf_illegal_q;
`endif

  assign inst_if.inst_ready = (state_q == S_IDLE);
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_opcode  = op_q;
  assign alu_sr_cont = sc_q;
  assign alu_sr_bit  = sb_q;
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_WB) && err_q;
  assign result      = result_q;
  assign cfg_drop    = drop_q;
  assign dbg_data    = regs_q[dbg_addr];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Bench for alu_seq_ctrl. Instance A (EXEC_CYCLES=1) is checked every
//   cycle against a transaction-timeline model; instance B (EXEC_CYCLES=3)
//   gets directed latency and mid-EXEC reset checks.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n, rst_n_b;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- ALU stand-in ----------------
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [2:0] sc,
                                        input logic [4:0] sb, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] s;
    logic [63:0] d;
    case (sc)
      3'd0:    s = y;
      3'd1:    s = y >> sb;
      3'd2:    s = y << sb;
      default: begin d = {y, y} >> sb; s = d[31:0]; end
    endcase
    case (op)
      4'd0:    return x + s;
      4'd1:    return x - s;
      4'd2:    return x & s;
      4'd3:    return x | s;
      4'd4:    return x ^ s;
      default: return s;
    endcase
  endfunction

  // ---------------- instance A ----------------
  alu_seq_ctrl_if ifa();
  logic [31:0] a_in1, a_in2, a_out, a_result, a_cfg_wdata, a_dbg_data;
  logic [3:0]  a_op, a_cfg_addr, a_dbg_addr;
  logic [2:0]  a_sc;
  logic [4:0]  a_sb;
  logic        a_done, a_err, a_cfg_we, a_drop;
  logic [1:0]  a_state;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] a_perf_ret;
  logic [15:0] a_perf_ill;
`endif
  assign a_out = alu_f(a_op, a_sc, a_sb, a_in1, a_in2);

  alu_seq_ctrl #(.EXEC_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .inst_if(ifa.slave),
    .alu_in1(a_in1), .alu_in2(a_in2), .alu_opcode(a_op), .alu_sr_cont(a_sc),
    .alu_sr_bit(a_sb), .alu_out(a_out), .done(a_done), .err(a_err),
    .result(a_result), .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr),
    .cfg_wdata(a_cfg_wdata), .cfg_drop(a_drop), .dbg_addr(a_dbg_addr),
    .dbg_data(a_dbg_data), .dbg_state(a_state)
`ifdef ALU_SEQ_PERF_EN
    , .perf_retired(a_perf_ret), .perf_illegal(a_perf_ill)
`endif
  );

  // ---------------- instance B ----------------
  alu_seq_ctrl_if ifb();
  logic [31:0] b_in1, b_in2, b_out, b_result, b_cfg_wdata, b_dbg_data;
  logic [3:0]  b_op, b_cfg_addr, b_dbg_addr;
  logic [2:0]  b_sc;
  logic [4:0]  b_sb;
  logic        b_done, b_err, b_cfg_we, b_drop;
  logic [1:0]  b_state;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] b_perf_ret;
  logic [15:0] b_perf_ill;
`endif
  assign b_out = alu_f(b_op, b_sc, b_sb, b_in1, b_in2);

  alu_seq_ctrl #(.EXEC_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .inst_if(ifb.slave),
    .alu_in1(b_in1), .alu_in2(b_in2), .alu_opcode(b_op), .alu_sr_cont(b_sc),
    .alu_sr_bit(b_sb), .alu_out(b_out), .done(b_done), .err(b_err),
    .result(b_result), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
    .cfg_wdata(b_cfg_wdata), .cfg_drop(b_drop), .dbg_addr(b_dbg_addr),
    .dbg_data(b_dbg_data), .dbg_state(b_state)
`ifdef ALU_SEQ_PERF_EN
    , .perf_retired(b_perf_ret), .perf_illegal(b_perf_ill)
`endif
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of instance A ----------------
  // Timeline per instruction: accept edge t=0, operands read at t=1, legal
  // writeback at t=1+EXEC, done visible after the writeback (or, if illegal,
  // after t=1) for one cycle, ready again one edge later.
  localparam int EXEC_A = 1;
  logic [31:0] m_reg [16];
  logic [31:0] m_result, m_in1, m_in2, m_res, m_word;
  logic [3:0]  m_op;
  logic [2:0]  m_sc;
  logic [4:0]  m_sb;
  logic        m_inflight, m_legal, m_done, m_err, m_drop;
  int          m_t;
  logic [31:0] m_retired;
  logic [15:0] m_illegal;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
    m_result = 0; m_in1 = 0; m_in2 = 0; m_op = 0; m_sc = 0; m_sb = 0; m_res = 0;
    m_inflight = 0; m_legal = 0; m_done = 0; m_err = 0; m_drop = 0; m_t = 0;
    m_word = 0; m_retired = 0; m_illegal = 0;
  endtask

  task automatic model_edge();
    logic [3:0] rd;
    logic       wb;
    int         wb_t;
    wb = 0;
    if (m_done) begin
      m_retired = m_retired + 1;
      if (m_err) m_illegal = m_illegal + 1;
    end
    rd = m_word[19:16];
    if (m_inflight) begin
      m_t++;
      wb_t = m_legal ? 1 + EXEC_A : 1;
      if (m_t == 1 && m_legal) begin
        m_op  = m_word[31:28];
        m_sc  = m_word[27:25];
        m_sb  = m_word[24:20];
        m_in1 = m_reg[m_word[15:12]];
        m_in2 = m_reg[m_word[11:8]];
        m_res = alu_f(m_op, m_sc, m_sb, m_in1, m_in2);
      end
      if (m_legal && m_t == wb_t) begin
        m_result = m_res;
        wb = 1;
      end
      if (m_t == wb_t + 1) m_inflight = 0;
    end else if (ifa.inst_valid) begin
      m_inflight = 1;
      m_t        = 0;
      m_word     = ifa.inst;
      m_legal    = (ifa.inst[31:28] <= 4'd5) && (ifa.inst[27:25] <= 3'd3);
    end
    m_drop = 0;
    if (a_cfg_we && a_cfg_addr != 0) begin
      if (wb && rd != 0 && a_cfg_addr == rd) m_drop = 1;
      else m_reg[a_cfg_addr] = a_cfg_wdata;
    end
    if (wb && rd != 0) m_reg[rd] = m_result;
    wb_t   = m_legal ? 1 + EXEC_A : 1;
    m_done = m_inflight && (m_t == wb_t);
    m_err  = m_done && !m_legal;
  endtask

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    check("a_ready",  {31'd0, ifa.inst_ready}, {31'd0, !m_inflight});
    check("a_done",   {31'd0, a_done}, {31'd0, m_done});
    check("a_err",    {31'd0, a_err},  {31'd0, m_err});
    check("a_drop",   {31'd0, a_drop}, {31'd0, m_drop});
    check("a_result", a_result, m_result);
    check("a_in1",    a_in1, m_in1);
    check("a_in2",    a_in2, m_in2);
    check("a_ctrl",   {20'd0, a_op, a_sc, a_sb}, {20'd0, m_op, m_sc, m_sb});
    check("a_dbg",    a_dbg_data, m_reg[a_dbg_addr]);
`ifdef ALU_SEQ_PERF_EN
    check("a_perf_ret", a_perf_ret, m_retired);
    check("a_perf_ill", {16'd0, a_perf_ill}, {16'd0, m_illegal});
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic cfg_a(input logic [3:0] addr, input logic [31:0] data);
    a_cfg_we = 1; a_cfg_addr = addr; a_cfg_wdata = data;
    step();
    a_cfg_we = 0;
  endtask

  task automatic issue_a(input logic [31:0] w);
    int n;
    n = 0;
    while (!ifa.inst_ready && n < 20) begin step(); n++; end
    if (!ifa.inst_ready) begin
      n_checks++; n_err++;
      $display("FAIL issue_a_timeout: ready=0 after 20 cycles");
    end
    ifa.inst_valid = 1; ifa.inst = w;
    step();
    ifa.inst_valid = 0;
  endtask

  task automatic cfg_b(input logic [3:0] addr, input logic [31:0] data);
    b_cfg_we = 1; b_cfg_addr = addr; b_cfg_wdata = data;
    step();
    b_cfg_we = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, dones;
    logic [31:0] w;
    rst_n = 0; rst_n_b = 0;
    model_reset();
    ifa.inst_valid = 0; ifa.inst = 0; ifb.inst_valid = 0; ifb.inst = 0;
    a_cfg_we = 0; a_cfg_addr = 0; a_cfg_wdata = 0; a_dbg_addr = 0;
    b_cfg_we = 0; b_cfg_addr = 0; b_cfg_wdata = 0; b_dbg_addr = 0;
    repeat (2) step();
    check("reset_ready", {31'd0, ifa.inst_ready}, 32'd1);
    check("reset_result", a_result, 32'd0);
    rst_n = 1; rst_n_b = 1;
    step();

    // Shifted ADD
    cfg_a(4'd1, 32'd5);
    cfg_a(4'd2, 32'd3);
    issue_a(32'h0443_1200);
    step();
    check("t1_sr_cont", {29'd0, a_sc}, 32'd2);
    check("t1_sr_bit",  {27'd0, a_sb}, 32'd4);
    step();
    check("t1_done", {31'd0, a_done}, 32'd1);
    check("t1_result", a_result, 32'h35);
    a_dbg_addr = 4'd3; #1;
    check("t1_dbg_r3", a_dbg_data, 32'h35);
    step();
    check("t1_done_once", {31'd0, a_done}, 32'd0);

    // Collision: cfg R3 on the writeback edge
    issue_a(32'h0443_1200);
    step();
    a_cfg_we = 1; a_cfg_addr = 4'd3; a_cfg_wdata = 32'hAAAA;
    step();
    a_cfg_we = 0;
    check("t5_drop", {31'd0, a_drop}, 32'd1);
    check("t5_r3", a_dbg_data, 32'h35);
    step();
    check("t5_drop_once", {31'd0, a_drop}, 32'd0);

    // Rotated SUB
    cfg_a(4'd1, 32'd0);
    cfg_a(4'd2, 32'h0000_00FF);
    issue_a(32'h1684_1200);
    step(); step();
    check("t2_done", {31'd0, a_done}, 32'd1);
    check("t2_err", {31'd0, a_err}, 32'd0);
    a_dbg_addr = 4'd4; #1;
    check("t2_r4", a_dbg_data, 32'h0100_0000);
    step();

    // Illegal opcode
    issue_a(32'h7000_0000);
    step();
    check("t3_done", {31'd0, a_done}, 32'd1);
    check("t3_err", {31'd0, a_err}, 32'd1);
    check("t3_result_held", a_result, 32'h0100_0000);
    step();

    // R0 protection
    cfg_a(4'd1, 32'd7);
    cfg_a(4'd2, 32'd7);
    issue_a(32'h0000_1200);
    step(); step();
    check("t4_result", a_result, 32'd14);
    a_dbg_addr = 4'd0; #1;
    check("t4_r0", a_dbg_data, 32'd0);
    step();
    cfg_a(4'd0, 32'hDEAD);
    check("t4_r0_cfg", a_dbg_data, 32'd0);
    check("t4_no_drop", {31'd0, a_drop}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      ifa.inst_valid = ($urandom_range(0, 1) == 1);
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 7));
      w[27:25] = 3'($urandom_range(0, 4));
      ifa.inst = w;
      a_cfg_we = ($urandom_range(0, 2) == 0);
      a_cfg_addr = (m_inflight && $urandom_range(0, 1) == 1) ? m_word[19:16]
                                                             : 4'($urandom_range(0, 15));
      a_cfg_wdata = $urandom;
      a_dbg_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        model_reset();
        step(); step();
        rst_n = 1;
      end
      step();
    end
    ifa.inst_valid = 0; a_cfg_we = 0;
    repeat (6) step();

    // Instance B: latency with EXEC_CYCLES=3
    cfg_b(4'd1, 32'd5);
    cfg_b(4'd2, 32'd3);
    check("b_ready_idle", {31'd0, ifb.inst_ready}, 32'd1);
    ifb.inst_valid = 1; ifb.inst = 32'h0443_1200;
    step();
    ifb.inst_valid = 0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (b_done) begin n = i; break; end
    end
    check("b_latency", n, 32'd4);
    check("b_result", b_result, 32'h35);
    step();
    check("b_done_once", {31'd0, b_done}, 32'd0);
    check("b_ready_back", {31'd0, ifb.inst_ready}, 32'd1);

    // Instance B: reset in the 2nd EXEC cycle
    ifb.inst_valid = 1; ifb.inst = 32'h0443_1200;
    step();
    ifb.inst_valid = 0;
    step(); step();
    check("b_busy", {31'd0, ifb.inst_ready}, 32'd0);
    rst_n_b = 0; #1;
    check("b_rst_ready", {31'd0, ifb.inst_ready}, 32'd1);
    check("b_rst_done", {31'd0, b_done}, 32'd0);
    check("b_rst_result", b_result, 32'd0);
    check("b_rst_in1", b_in1, 32'd0);
    step(); step();
    rst_n_b = 1; #1;
    check("b_rel_ready", {31'd0, ifb.inst_ready}, 32'd1);
    for (int r = 0; r < 16; r++) begin
      b_dbg_addr = 4'(r); #1;
      check("b_rst_reg", b_dbg_data, 32'd0);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_done) dones++;
    end
    check("b_no_done", dones, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
